// File: rtl/bus_slave_if.sv
// Bus slave front end: turns accepted bus beats into single backend requests,
// with burst tracking, transfer legality checks and a backend timeout.
module bus_slave_if #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned AW      = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          SxSEL,
  input  logic          MmWT,
  input  logic [2:0]    MmSZ,
  input  logic [3:0]    MmRB,
  input  logic [2:0]    MmMOD,
  input  logic [31:0]   MmADDR,
  input  logic [31:0]   MmWDT,
  output logic          SxRDY,
  output logic          SxERR,
  output logic [31:0]   SxRDT,
  output logic          BREQ,
  output logic          BWE,
  output logic [AW-1:0] BADDR,
  output logic [3:0]    BBE,
  output logic [31:0]   BWDT,
  input  logic          BACK,
  input  logic [31:0]   BRDT
);

  localparam int unsigned     TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [2:0] {
    M_IDLE   = 3'b000,
    M_BUSY   = 3'b001,
    M_NONSEQ = 3'b010,
    M_SEQ    = 3'b011
  } mode_t;

  state_t        state, state_nx;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] seq_addr;
  logic [2:0]    sz_q;
  logic          wt_q;
  logic [3:0]    be_q;
  logic [3:0]    bcnt;
  logic [TW-1:0] tcnt;
  logic [31:0]   rdt_q;
  logic          burst;
  logic          is_seq;
  logic          xfer;
  logic          take;
  logic          legal;
  logic          tmo;

  function automatic logic size_ok(input logic [2:0] sz, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (sz)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~off[0];
      3'b010:  ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] sz, input logic [1:0] off);
    logic [3:0] be;
    be = '0;
    case (sz)
      3'b000:  be = 4'b0001 << off;
      3'b001:  be = off[1] ? 4'b1100 : 4'b0011;
      3'b010:  be = 4'b1111;
      default: be = '0;
    endcase
    return be;
  endfunction

  assign burst    = (bcnt != '0);
  assign is_seq   = (MmMOD == M_SEQ);
  assign xfer     = SxSEL & ((MmMOD == M_NONSEQ) | is_seq);
  // ERR also shows ready, but a beat offered there is deliberately dropped
  assign take     = xfer & ((state == S_IDLE) | (state == S_DONE));
  assign legal    = is_seq ? burst : (~burst & size_ok(MmSZ, MmADDR[1:0]));
  assign seq_addr = addr_q + (AW'(1) << sz_q);
  assign tmo      = (tcnt == TLAST);

  assign BWE   = wt_q;
  assign BADDR = addr_q;
  assign BBE   = be_q;
  assign BWDT  = MmWDT;
  assign SxRDT = rdt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    SxRDY    = 1'b1;
    SxERR    = 1'b0;
    BREQ     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (take) begin
          state_nx = legal ? S_REQ : S_ERR;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_REQ: begin
        SxRDY = 1'b0;
        BREQ  = 1'b1;
        if (BACK) begin
          state_nx = S_DONE;
        end else if (tmo) begin
          state_nx = S_ERR;
        end
      end
      S_ERR: begin
        SxERR    = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q <= '0;
      sz_q   <= '0;
      wt_q   <= 1'b0;
      be_q   <= '0;
      bcnt   <= '0;
      tcnt   <= '0;
      rdt_q  <= '0;
    end else begin
      if (take && legal) begin
        wt_q <= MmWT;
        tcnt <= '0;
        if (is_seq) begin
          // SEQ beats follow the burst's own address/size, not the bus
          addr_q <= seq_addr;
          be_q   <= byte_en(sz_q, seq_addr[1:0]);
          bcnt   <= bcnt - 4'd1;
        end else begin
          addr_q <= AW'(MmADDR);
          sz_q   <= MmSZ;
          be_q   <= byte_en(MmSZ, MmADDR[1:0]);
          bcnt   <= MmRB;
        end
      end
      if (state == S_REQ) begin
        tcnt <= tcnt + TW'(1);
        if (BACK && !wt_q) begin
          rdt_q <= BRDT;
        end
      end
      if (state == S_ERR) begin
        bcnt <= '0;
      end
    end
  end

endmodule
